fmdll_lock_ctrl: RTL and testbench

- Parametrised lock controller for the frequency-multiplying DLL.
- Replaces the fixed 2-bit/4-bit/6-bit control path with generic widths.
- Generates the every-M reference-injection select, runs binary-search then tracking adjustment of the DCDL delay code from phase-detector decisions, and reports lock with loss-of-lock detection.
- Runs entirely in the CLK_exit domain; phase-detector outputs arrive already synchronised.

---
 rtl/fmdll_pkg.sv | 6 +
 rtl/fmdll_lock_ctrl_if.sv | 7 +
 rtl/fmdll_mdiv.sv | 29 ++
 rtl/fmdll_lock_ctrl.sv | 105 ++++++++++
 tb/tb_fmdll_lock_ctrl.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/fmdll_pkg.sv
// fmdll_pkg: shared FSM state, PD direction and clock-mux select encodings for the FMDLL lock controller
package fmdll_pkg;
  typedef enum logic [2:0] {IDLE = 3'd0, COARSE = 3'd1, FINE = 3'd2, LOCKED = 3'd3} state_t;
  typedef enum logic [1:0] {NONE, UP, DN} dir_t;
  localparam logic [1:0] SEL_FB = 2'b00, SEL_REF = 2'b01, SEL_OFF = 2'b10;
endpackage

// File: rtl/fmdll_lock_ctrl_if.sv
// fmdll_lock_ctrl_if: phase-detector sample bus (pd_valid strobe with pd_lead/pd_lag decisions)
//   master: drives the PD sample; slave: the lock controller consuming it
interface fmdll_lock_ctrl_if;
  logic pd_valid, pd_lead, pd_lag;
  modport master(output pd_valid, pd_lead, pd_lag);
  modport slave(input pd_valid, pd_lead, pd_lag);
endinterface

// File: rtl/fmdll_mdiv.sv
// fmdll_mdiv: captures the injection period M (0 read as 1) and pulses div_m at the end of each period
//   CLK_exit, rst_n : clock, async active-low reset
//   M, cfg_load     : period input, capture/restart pulse
//   div_m           : high when the period counter sits at Mq-1
module fmdll_mdiv #(parameter int M_W = 2) (
  input  logic           CLK_exit,
  input  logic           rst_n,
  input  logic [M_W-1:0] M,
  input  logic           cfg_load,
  output logic           div_m
);
  logic [M_W-1:0] mq, cnt;
  logic first, tc;
  assign tc = cnt == mq - 1'b1;
  // first is still set during the cycle after reset release, which keeps div_m at its reset value of 0
  assign div_m = !first && tc;
  always_ff @(posedge CLK_exit or negedge rst_n)
    if (!rst_n) begin
      mq <= M_W'(1);
      cnt <= '0;
      first <= 1'b1;
    end else begin
      first <= 1'b0;
      if (first || cfg_load) begin
        mq <= M == '0 ? M_W'(1) : M;
        cnt <= '0;
      end else cnt <= tc ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/fmdll_lock_ctrl.sv
// fmdll_lock_ctrl: FMDLL lock controller - reference-injection select, binary-search then tracking of the DCDL code, lock detect
//   CLK_exit, rst_n : sole clock, async active-low reset
//   M, cfg_load     : injection period, capture/restart pulse
//   pd              : phase-detector sample bus (slave modport)
//   freeze          : present only with FMDLL_FREEZE_EN; holds code/counters while LOCKED
//   Sel, DIV_M      : clock-mux select (00 fb, 01 ref, 10 off), end-of-period pulse
//   code, locked    : DCDL delay code, lock indicator
//   state           : FSM state for debug
module fmdll_lock_ctrl
  import fmdll_pkg::*;
#(
  parameter int M_W        = 2,
  parameter int CODE_W     = 6,
  parameter int LOCK_CNT   = 8,
  parameter int UNLOCK_RUN = 4
) (
  input  logic              CLK_exit,
  input  logic              rst_n,
  input  logic [M_W-1:0]    M,
  input  logic              cfg_load,
`ifdef FMDLL_FREEZE_EN
  input  logic              freeze,
`endif
  fmdll_lock_ctrl_if.slave  pd,
  output logic [1:0]        Sel,
  output logic              DIV_M,
  output logic [CODE_W-1:0] code,
  output logic              locked,
  output logic [2:0]        state
);
  localparam int IDX_W = CODE_W > 1 ? $clog2(CODE_W) : 1;
  localparam logic [3:0] UR = 4'(UNLOCK_RUN);
  localparam logic [7:0] LC = 8'(LOCK_CNT);
  state_t st, st_n;
  dir_t dir, last, last_n;
  logic [CODE_W-1:0] code_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [3:0] run, run_n;
  logic [7:0] lcnt, lcnt_n;
  logic smp, frz;
`ifdef FMDLL_FREEZE_EN
  assign frz = freeze && st == LOCKED;
`else
  assign frz = 1'b0;
`endif
  fmdll_mdiv #(.M_W(M_W)) u_mdiv (.CLK_exit(CLK_exit), .rst_n(rst_n), .M(M), .cfg_load(cfg_load), .div_m(DIV_M));
  assign smp = pd.pd_valid && !frz;
  assign dir = pd.pd_lead && !pd.pd_lag ? UP : pd.pd_lag && !pd.pd_lead ? DN : NONE;
  assign Sel = st == IDLE ? SEL_OFF : DIV_M ? SEL_REF : SEL_FB;
  assign locked = st == LOCKED;
  assign state = st;
  always_comb begin
    st_n = st;
    code_n = code;
    idx_n = idx;
    run_n = run;
    lcnt_n = lcnt;
    last_n = last;
    if (cfg_load || st == IDLE) begin
      st_n = cfg_load ? IDLE : COARSE;
      run_n = '0;
      lcnt_n = '0;
      last_n = NONE;
      if (!cfg_load) begin
        code_n = {1'b1, {(CODE_W-1){1'b0}}};
        idx_n = IDX_W'(CODE_W-1);
      end
    end else if (st == COARSE && smp) begin
      code_n[idx] = !pd.pd_lag;
      if (idx == '0) st_n = FINE;
      else begin
        code_n[idx-1'b1] = 1'b1;
        idx_n = idx - 1'b1;
      end
    end else if ((st == FINE || st == LOCKED) && smp) begin
      code_n = dir == UP ? (&code ? code : code + 1'b1) : dir == DN ? (|code ? code - 1'b1 : code) : code;
      // a saturated attempt still counts toward the run; run saturates at the unlock threshold
      run_n = dir == NONE ? 4'd0 : dir == last ? (run >= UR ? run : run + 1'b1) : 4'd1;
      // any sample that does not extend a trend (hold or new direction) counts toward lock
      lcnt_n = run_n >= 4'd2 ? 8'd0 : &lcnt ? lcnt : lcnt + 1'b1;
      last_n = dir;
      if (st == FINE && lcnt_n >= LC) st_n = LOCKED;
      if (st == LOCKED && run_n >= UR) begin
        st_n = FINE;
        lcnt_n = '0;
      end
    end
  end
  always_ff @(posedge CLK_exit or negedge rst_n)
    if (!rst_n) begin
      st <= IDLE;
      code <= '0;
      idx <= '0;
      run <= '0;
      lcnt <= '0;
      last <= NONE;
    end else begin
      st <= st_n;
      code <= code_n;
      idx <= idx_n;
      run <= run_n;
      lcnt <= lcnt_n;
      last <= last_n;
    end
endmodule

// File: tb/tb_fmdll_lock_ctrl.sv
// tb_fmdll_lock_ctrl: directed self-checking bench for fmdll_lock_ctrl (M_W=2, CODE_W=6, LOCK_CNT=8, UNLOCK_RUN=4)
module tb_fmdll_lock_ctrl;
  logic CLK_exit = 1'b0, rst_n = 1'b0, cfg_load = 1'b0;
  logic [1:0] M = 2'd3;
  logic [1:0] Sel;
  logic DIV_M, locked;
  logic [5:0] code;
  logic [2:0] state;
  int pass = 0, tot = 0;
`ifdef FMDLL_FREEZE_EN
  logic freeze = 1'b0;
`endif
  fmdll_lock_ctrl_if pd_if();
  fmdll_lock_ctrl #(.M_W(2), .CODE_W(6), .LOCK_CNT(8), .UNLOCK_RUN(4)) dut (
    .CLK_exit(CLK_exit), .rst_n(rst_n), .M(M), .cfg_load(cfg_load),
`ifdef FMDLL_FREEZE_EN
    .freeze(freeze),
`endif
    .pd(pd_if), .Sel(Sel), .DIV_M(DIV_M), .code(code), .locked(locked), .state(state));
  always #5 CLK_exit = ~CLK_exit;

  task automatic tick;
    @(posedge CLK_exit);
    #1;
  endtask

  task automatic sample(input logic lead, input logic lag);
    pd_if.pd_valid = 1'b1;
    pd_if.pd_lead = lead;
    pd_if.pd_lag = lag;
    tick();
    pd_if.pd_valid = 1'b0;
    pd_if.pd_lead = 1'b0;
    pd_if.pd_lag = 1'b0;
  endtask

  task automatic test_reset;
    pd_if.pd_valid = 1'b0;
    pd_if.pd_lead = 1'b0;
    pd_if.pd_lag = 1'b0;
    tick();
    tick();
    tot++; if (Sel !== 2'b10) $display("FAIL rst_sel got %b want 10", Sel); else pass++;
    tot++; if (DIV_M !== 1'b0) $display("FAIL rst_divm got %b want 0", DIV_M); else pass++;
    tot++; if (code !== 6'd0) $display("FAIL rst_code got %0d want 0", code); else pass++;
    tot++; if (locked !== 1'b0) $display("FAIL rst_locked got %b want 0", locked); else pass++;
    tot++; if (state !== 3'd0) $display("FAIL rst_state got %0d want 0", state); else pass++;
  endtask

  task automatic test_release_m3;
    logic [1:0] es;
    rst_n = 1'b1;
    tot++; if (Sel !== 2'b10) $display("FAIL rel_idle_sel got %b want 10", Sel); else pass++;
    tick();
    tot++; if (state !== 3'd1) $display("FAIL rel_state got %0d want 1", state); else pass++;
    tot++; if (code !== 6'd32) $display("FAIL rel_code got %0d want 32", code); else pass++;
    for (int i = 0; i < 9; i++) begin
      es = (i % 3 == 2) ? 2'b01 : 2'b00;
      tot++; if (DIV_M !== es[0]) $display("FAIL m3_divm[%0d] got %b want %b", i, DIV_M, es[0]); else pass++;
      tot++; if (Sel !== es) $display("FAIL m3_sel[%0d] got %b want %b", i, Sel, es); else pass++;
      tick();
    end
  endtask

  task automatic test_coarse;
    logic lagv [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [5:0] expc [6] = '{6'b010000, 6'b011000, 6'b010100, 6'b010110, 6'b010111, 6'b010110};
    for (int i = 0; i < 6; i++) begin
      sample(1'b0, lagv[i]);
      tot++; if (code !== expc[i]) $display("FAIL coarse_code[%0d] got %b want %b", i, code, expc[i]); else pass++;
    end
    tot++; if (state !== 3'd2) $display("FAIL coarse_state got %0d want 2", state); else pass++;
  endtask

  task automatic test_lock_unlock;
    logic [5:0] ec;
    pd_if.pd_lead = 1'b1;
    tick();
    pd_if.pd_lead = 1'b0;
    tot++; if (code !== 6'd22) $display("FAIL novalid_code got %0d want 22", code); else pass++;
    for (int i = 0; i < 8; i++) begin
      sample(i % 2 == 1, i % 2 == 0);
      ec = (i % 2 == 0) ? 6'd21 : 6'd22;
      tot++; if (code !== ec) $display("FAIL alt_code[%0d] got %0d want %0d", i, code, ec); else pass++;
      tot++; if (locked !== (i == 7)) $display("FAIL alt_locked[%0d] got %b want %b", i, locked, i == 7); else pass++;
    end
    tot++; if (state !== 3'd3) $display("FAIL lock_state got %0d want 3", state); else pass++;
    for (int i = 0; i < 4; i++) begin
      sample(1'b0, 1'b1);
      tot++; if (locked !== (i < 3)) $display("FAIL run_locked[%0d] got %b want %b", i, locked, i < 3); else pass++;
    end
    tot++; if (state !== 3'd2) $display("FAIL unlock_state got %0d want 2", state); else pass++;
    tot++; if (code !== 6'd18) $display("FAIL unlock_code got %0d want 18", code); else pass++;
    sample(1'b1, 1'b1);
    tot++; if (code !== 6'd18) $display("FAIL hold_code got %0d want 18", code); else pass++;
    for (int i = 0; i < 7; i++) begin
      sample(1'b0, 1'b0);
      tot++; if (locked !== (i == 6)) $display("FAIL relock[%0d] got %b want %b", i, locked, i == 6); else pass++;
    end
  endtask

  task automatic test_cfg_load_m0;
    M = 2'd0;
    cfg_load = 1'b1;
    pd_if.pd_valid = 1'b1;
    pd_if.pd_lead = 1'b1;
    tick();
    cfg_load = 1'b0;
    pd_if.pd_valid = 1'b0;
    pd_if.pd_lead = 1'b0;
    tot++; if (state !== 3'd0) $display("FAIL cfg_state got %0d want 0", state); else pass++;
    tot++; if (code !== 6'd18) $display("FAIL cfg_code got %0d want 18", code); else pass++;
    tot++; if (locked !== 1'b0) $display("FAIL cfg_locked got %b want 0", locked); else pass++;
    tot++; if (Sel !== 2'b10) $display("FAIL cfg_sel got %b want 10", Sel); else pass++;
    tick();
    tot++; if (state !== 3'd1) $display("FAIL cfg_coarse got %0d want 1", state); else pass++;
    tot++; if (code !== 6'd32) $display("FAIL cfg_code32 got %0d want 32", code); else pass++;
    for (int i = 0; i < 5; i++) begin
      tot++; if (DIV_M !== 1'b1) $display("FAIL m0_divm[%0d] got %b want 1", i, DIV_M); else pass++;
      tot++; if (Sel !== 2'b01) $display("FAIL m0_sel[%0d] got %b want 01", i, Sel); else pass++;
      tick();
    end
  endtask

  task automatic test_saturate;
    for (int i = 0; i < 6; i++) sample(1'b0, 1'b0);
    tot++; if (code !== 6'd63) $display("FAIL sat_coarse_code got %0d want 63", code); else pass++;
    tot++; if (state !== 3'd2) $display("FAIL sat_state got %0d want 2", state); else pass++;
    for (int i = 0; i < 5; i++) begin
      sample(1'b1, 1'b0);
      tot++; if (code !== 6'd63) $display("FAIL sat_code[%0d] got %0d want 63", i, code); else pass++;
      tot++; if (locked !== 1'b0) $display("FAIL sat_locked[%0d] got %b want 0", i, locked); else pass++;
    end
    sample(1'b0, 1'b1);
    tot++; if (code !== 6'd62) $display("FAIL sat_dec got %0d want 62", code); else pass++;
  endtask

  task automatic test_async_reset;
    #2;
    rst_n = 1'b0;
    #1;
    tot++; if (code !== 6'd0) $display("FAIL arst_code got %0d want 0", code); else pass++;
    tot++; if (state !== 3'd0) $display("FAIL arst_state got %0d want 0", state); else pass++;
    tot++; if (Sel !== 2'b10) $display("FAIL arst_sel got %b want 10", Sel); else pass++;
    tot++; if (DIV_M !== 1'b0) $display("FAIL arst_divm got %b want 0", DIV_M); else pass++;
  endtask

  initial begin
    test_reset();
    test_release_m3();
    test_coarse();
    test_lock_unlock();
    test_cfg_load_m0();
    test_saturate();
    test_async_reset();
    $display("%0d/%0d checks passed", pass, tot);
    $finish;
  end
endmodule
